// File: rtl/pulse_xfer_tx.sv
// Source side of a toggle req/ack pulse-crossing channel: counts event pulses, launches one req toggle per event.
// Optional wait-for-ack timeout flag enabled by defining PULSE_XFER_TIMEOUT_EN.
module pulse_xfer_tx #(
    parameter int CNT_W          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_in,
    input  logic             clr_overflow,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
`ifdef PULSE_XFER_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    logic   launch;
    logic   ack_s;
    logic   cnt_sat;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync;

    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign cnt_sat = (pending == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if ((pending != '0) || pulse_in) begin
                    launch    = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s == req_out) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // req_out and busy are kept as bare flops so nothing glitchy reaches the remote domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_out <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (launch) begin
                req_out <= ~req_out;
            end
            busy <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (pulse_in && !launch) begin
                if (!cnt_sat) begin
                    pending <= pending + 1'b1;
                end
            end else if (!pulse_in && launch) begin
                pending <= pending - 1'b1;
            end

            if (pulse_in && !launch && cnt_sat) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef PULSE_XFER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] wait_cnt;

    // counter saturates at the limit so a very long wait cannot wrap back to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (launch) begin
                wait_cnt <= '0;
            end else if ((state == WAIT_ACK) && (wait_cnt != T_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if ((state == WAIT_ACK) && (wait_cnt == T_LIMIT)) begin
                timeout_err <= 1'b1;
            end else if (clr_overflow) begin
                timeout_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/pulse_xfer_tx.md
Name: pulse_xfer_tx

Overview:
- Source-side transmitter of a toggle req/ack pulse-crossing channel.
- Counts single-cycle event pulses arriving in its clk domain and sends each one to a remote domain as one transition of a level signal, req_out.
- Waits for the remote receiver to return a matching ack toggle, synchronized internally, before sending the next event. No event is lost while the pending counter has headroom.

Parameters:
- CNT_W, 8, width of the pending-event counter; maximum pending is 2^CNT_W-1.
- SYNC_STAGES, 2, number of flops in the ack_in synchronizer chain; legal range 2..4.
- TIMEOUT_CYCLES, 1023, WAIT_ACK cycle limit; used only when PULSE_XFER_TIMEOUT_EN is defined.

Ports:
- clk  input  1  source clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- pulse_in  input  1  event strobe; each high cycle is one event.
- ack_in  input  1  acknowledge toggle from the remote domain; asynchronous to clk.
- req_out  output  1  request toggle to the remote domain; a direct flop output with no logic after the register.
- busy  output  1  high while a transfer is outstanding (state WAIT_ACK or DONE).
- pending  output  CNT_W  events accepted but not yet launched.
- overflow  output  1  sticky flag: an event was dropped because the counter was saturated.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset values: req_out=0, busy=0, pending=0, overflow=0, ack synchronizer flops=0, state=IDLE.
- Ack synchronizer: SYNC_STAGES flops marked ASYNC_REG; the last stage is ack_s.
- FSM states: IDLE, WAIT_ACK, DONE.
- IDLE:
  - If (pending!=0 or pulse_in): toggle req_out, go to WAIT_ACK.
  - Launch latency is one edge: pulse_in high in cycle N with pending=0 gives req_out toggled after edge N.
- WAIT_ACK: remain until ack_s==req_out, then go to DONE.
- DONE: one-cycle gap; go to IDLE. The minimum spacing between req_out toggles is therefore SYNC_STAGES+3 cycles, assuming the receiver acks immediately.
- Pending counter update each cycle: inc = pulse_in, dec = launch in IDLE.
  - inc&dec: pending unchanged. This covers a launch fed directly by pulse_in with pending=0.
  - inc only: pending+1, saturating at 2^CNT_W-1.
  - At saturation, further inc is dropped and overflow is set on the next edge.
  - dec only: pending-1. pending is never decremented below 0 because a launch requires pending!=0 or pulse_in.
- overflow clearing:
  - Cleared by clr_overflow on the next edge.
  - A simultaneous set and clear results in set (set wins).
- busy is a registered decode: busy=1 in WAIT_ACK and DONE.
- Reset mid-transfer: all state returns to reset values, including req_out=0. The receiver and this block must be reset together; there is no protocol recovery across a one-sided reset.
- ack_in toggling while in IDLE or DONE (protocol violation): ignored, no state change.

Optional Feature:
- Macro: PULSE_XFER_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, sticky, reset 0) and a wait counter of width clog2(TIMEOUT_CYCLES+1).
  - The wait counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err sets on the next edge. The FSM keeps waiting; the flag does not cause recovery.
  - timeout_err is cleared by clr_overflow, with set winning on a simultaneous set and clear.
- Undefined: no timeout_err port, no counter; behaviour is otherwise identical.

Test Plan:
- Single event, receiver acks 3 cycles after seeing req (echo via 2-flop model):
  - pulse_in 1 cycle -> req_out 0->1 one edge later; busy=1.
  - After ack_s matches: busy falls; pending=0 throughout.
- Burst, ack held off:
  - 5 consecutive pulse_in cycles -> one launch immediately; pending climbs 1..4 and holds at 4.
  - Then 4 further req toggles, each after its ack; pending ends at 0; 5 total toggles.
- Saturation, CNT_W=2, no acks:
  - 6 pulses -> first launches, pending saturates at 3, remaining pulses dropped, overflow=1.
  - clr_overflow pulse -> overflow=0.
  - clr_overflow asserted together with a dropped pulse -> overflow stays 1.
- Pulse during DONE and during WAIT_ACK -> each counted in pending and launched in the next IDLE cycle; no event lost.
- Async reset mid-WAIT_ACK with pending=2 -> immediately req_out=0, busy=0, pending=0, overflow=0; a new pulse after release launches normally.
- PULSE_XFER_TIMEOUT_EN defined, TIMEOUT_CYCLES=10, no ack:
  - timeout_err=1 after 10 WAIT_ACK cycles.
  - A late ack then completes the transfer; timeout_err stays 1 until clr_overflow.
